// File: rtl/ava_vram_arbiter.sv
// ava_vram_arbiter: shares one VRAM BRAM port between display scan-out and the CPU bridge
//   clk_i, rst_ni              clock, async active-low reset
//   vblank_i                   CPU gets priority while high
//   disp_req_i/addr_i          display read request; disp_gnt_o, disp_rvalid_o, disp_rdata_o
//   cpu_req_i/addr/wdata/we    CPU request (we==0 is a read); cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o
//   vram_*                     BRAM port, read data one cycle after enable
//   cpu_starved_o              CPU slot forced by the starvation limiter this cycle
module ava_vram_arbiter #(
    parameter int VRAM_ADDR_WIDTH = 15,
    parameter int MAX_DISP_RUN    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       vblank_i,
    input  logic                       disp_req_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] disp_addr_i,
    output logic                       disp_gnt_o,
    output logic                       disp_rvalid_o,
    output logic [31:0]                disp_rdata_o,
    input  logic                       cpu_req_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]                cpu_wdata_i,
    input  logic [3:0]                 cpu_we_i,
    output logic                       cpu_gnt_o,
    output logic                       cpu_rvalid_o,
    output logic [31:0]                cpu_rdata_o,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_a_o,
    output logic [31:0]                vram_di_o,
    output logic                       vram_en_o,
    output logic [3:0]                 vram_we_o,
    input  logic [31:0]                vram_do_i,
    output logic                       cpu_starved_o
);
    typedef enum logic [1:0] {NONE, DISP, CPU} owner_e;
    owner_e     owner_q, owner_d;
    logic [3:0] starve_cnt, starve_d;
    logic       disp_req, cpu_req, force_cpu, cpu_win, disp_win;
    // Requests are masked while reset is held so every output stays 0.
    assign disp_req  = disp_req_i & rst_ni;
    assign cpu_req   = cpu_req_i & rst_ni;
    assign force_cpu = starve_cnt >= 4'(MAX_DISP_RUN);
    always_comb begin
        cpu_win  = cpu_req & (~disp_req | vblank_i | force_cpu);
        disp_win = disp_req & ~cpu_win;
        owner_d  = cpu_win ? CPU : (disp_win ? DISP : NONE);
        // Count only display wins that made the CPU wait; saturate at 15.
        starve_d = (disp_win & cpu_req) ? ((starve_cnt == 4'hf) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= NONE;
            starve_cnt <= 4'd0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
        end
    end
    assign disp_gnt_o    = disp_win;
    assign cpu_gnt_o     = cpu_win;
    assign vram_en_o     = cpu_win | disp_win;
    assign vram_a_o      = cpu_win ? cpu_addr_i : (disp_win ? disp_addr_i : '0);
    assign vram_we_o     = cpu_win ? cpu_we_i : 4'd0;
    assign vram_di_o     = cpu_win ? cpu_wdata_i : 32'd0;
    assign cpu_starved_o = force_cpu & cpu_req & disp_req;
    assign disp_rvalid_o = owner_q == DISP;
    assign cpu_rvalid_o  = owner_q == CPU;
    assign disp_rdata_o  = disp_rvalid_o ? vram_do_i : 32'd0;
    assign cpu_rdata_o   = cpu_rvalid_o ? vram_do_i : 32'd0;
endmodule

// File: tb/tb_ava_vram_arbiter.sv
// tb_ava_vram_arbiter: directed table plus sequences for the VRAM arbiter
module tb_ava_vram_arbiter;
    logic        clk_i = 0, rst_ni = 0, vblank_i = 0;
    logic        disp_req_i = 0, cpu_req_i = 0;
    logic [14:0] disp_addr_i = 0, cpu_addr_i = 0;
    logic [31:0] cpu_wdata_i = 0;
    logic [3:0]  cpu_we_i = 0;
    logic        disp_gnt_o, disp_rvalid_o, cpu_gnt_o, cpu_rvalid_o, vram_en_o, cpu_starved_o;
    logic [31:0] disp_rdata_o, cpu_rdata_o, vram_di_o, vram_do;
    logic [14:0] vram_a_o;
    logic [3:0]  vram_we_o;
    int          total = 0, passed = 0;

    ava_vram_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .vblank_i(vblank_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
        .disp_rvalid_o(disp_rvalid_o), .disp_rdata_o(disp_rdata_o),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_we_i(cpu_we_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o(cpu_rdata_o), .vram_a_o(vram_a_o), .vram_di_o(vram_di_o),
        .vram_en_o(vram_en_o), .vram_we_o(vram_we_o), .vram_do_i(vram_do),
        .cpu_starved_o(cpu_starved_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] mem [256];
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'h0;
            mem[8'h30] <= 32'h0;
        end else if (vram_en_o) begin
            vram_do <= mem[vram_a_o[7:0]];
            for (int b = 0; b < 4; b++)
                if (vram_we_o[b]) mem[vram_a_o[7:0]][8*b +: 8] <= vram_di_o[8*b +: 8];
        end
    end

    typedef struct {
        logic        vb, dr, cr;
        logic [14:0] da, ca;
        logic [31:0] wd;
        logic [3:0]  we;
        logic        dg, cg, en;
        logic [3:0]  ewe;
        logic [14:0] ea;
        logic [31:0] edi;
        logic        chkrd;
        logic [31:0] erd;
    } vec_t;
    vec_t v [9];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic vb, dr, cr, input logic [14:0] da, ca,
                         input logic [31:0] wd, input logic [3:0] we);
        vblank_i = vb; disp_req_i = dr; cpu_req_i = cr;
        disp_addr_i = da; cpu_addr_i = ca; cpu_wdata_i = wd; cpu_we_i = we;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, " dgnt"}, 32'(disp_gnt_o), 0);
        chk({n, " cgnt"}, 32'(cpu_gnt_o), 0);
        chk({n, " en"}, 32'(vram_en_o), 0);
        chk({n, " we"}, 32'(vram_we_o), 0);
        chk({n, " addr"}, 32'(vram_a_o), 0);
        chk({n, " di"}, vram_di_o, 0);
        chk({n, " drv"}, 32'(disp_rvalid_o), 0);
        chk({n, " crv"}, 32'(cpu_rvalid_o), 0);
        chk({n, " drd"}, disp_rdata_o, 0);
        chk({n, " crd"}, cpu_rdata_o, 0);
        chk({n, " starved"}, 32'(cpu_starved_o), 0);
    endtask

    initial begin
        v[0] = '{0,1,0, 15'h10,15'h00, 32'h0,        4'h0, 1,0,1, 4'h0, 15'h10, 32'h0,        1, 32'hDEADBEEF};
        v[1] = '{0,0,1, 15'h00,15'h20, 32'h12345678, 4'h3, 0,1,1, 4'h3, 15'h20, 32'h12345678, 0, 32'h0};
        v[2] = '{0,0,1, 15'h00,15'h20, 32'h0,        4'h0, 0,1,1, 4'h0, 15'h20, 32'h0,        1, 32'h00005678};
        v[3] = '{0,1,1, 15'h10,15'h20, 32'hFFFFFFFF, 4'hF, 1,0,1, 4'h0, 15'h10, 32'h0,        1, 32'hDEADBEEF};
        v[4] = '{1,1,1, 15'h10,15'h20, 32'h0,        4'h0, 0,1,1, 4'h0, 15'h20, 32'h0,        1, 32'h00005678};
        v[5] = '{0,0,0, 15'h40,15'h41, 32'h55,       4'hF, 0,0,0, 4'h0, 15'h0,  32'h0,        0, 32'h0};
        v[6] = '{1,1,0, 15'h10,15'h20, 32'h0,        4'h0, 1,0,1, 4'h0, 15'h10, 32'h0,        1, 32'hDEADBEEF};
        v[7] = '{1,1,1, 15'h10,15'h30, 32'hAABBCCDD, 4'hF, 0,1,1, 4'hF, 15'h30, 32'hAABBCCDD, 0, 32'h0};
        v[8] = '{0,0,1, 15'h10,15'h30, 32'h0,        4'h0, 0,1,1, 4'h0, 15'h30, 32'h0,        1, 32'hAABBCCDD};

        drive(0, 1, 1, 15'h10, 15'h20, 32'h1, 4'hF);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_ni = 1;
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            drive(v[i].vb, v[i].dr, v[i].cr, v[i].da, v[i].ca, v[i].wd, v[i].we);
            @(negedge clk_i);
            chk($sformatf("v%0d dgnt", i), 32'(disp_gnt_o), 32'(v[i].dg));
            chk($sformatf("v%0d cgnt", i), 32'(cpu_gnt_o), 32'(v[i].cg));
            chk($sformatf("v%0d en", i), 32'(vram_en_o), 32'(v[i].en));
            chk($sformatf("v%0d we", i), 32'(vram_we_o), 32'(v[i].ewe));
            chk($sformatf("v%0d addr", i), 32'(vram_a_o), 32'(v[i].ea));
            chk($sformatf("v%0d di", i), vram_di_o, v[i].edi);
            chk($sformatf("v%0d starved", i), 32'(cpu_starved_o), 0);
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk_i);
            chk($sformatf("v%0d drv", i), 32'(disp_rvalid_o), 32'(v[i].dg));
            chk($sformatf("v%0d crv", i), 32'(cpu_rvalid_o), 32'(v[i].cg));
            chk($sformatf("v%0d drd", i), disp_rdata_o, v[i].dg ? v[i].erd : 32'h0);
            if (v[i].chkrd || !v[i].cg)
                chk($sformatf("v%0d crd", i), cpu_rdata_o, v[i].cg ? v[i].erd : 32'h0);
            next_cycle();
        end

        drive(0, 1, 1, 15'h10, 15'h20, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk($sformatf("cont%0d dgnt", i), 32'(disp_gnt_o), (i % 5 != 4) ? 1 : 0);
            chk($sformatf("cont%0d cgnt", i), 32'(cpu_gnt_o), (i % 5 == 4) ? 1 : 0);
            chk($sformatf("cont%0d starved", i), 32'(cpu_starved_o), (i % 5 == 4) ? 1 : 0);
            if (i > 0) begin
                chk($sformatf("cont%0d drv", i), 32'(disp_rvalid_o), ((i - 1) % 5 != 4) ? 1 : 0);
                chk($sformatf("cont%0d crv", i), 32'(cpu_rvalid_o), ((i - 1) % 5 == 4) ? 1 : 0);
                chk($sformatf("cont%0d drd", i), disp_rdata_o, ((i - 1) % 5 != 4) ? 32'hDEADBEEF : 32'h0);
                chk($sformatf("cont%0d crd", i), cpu_rdata_o, ((i - 1) % 5 == 4) ? 32'h00005678 : 32'h0);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        drive(1, 1, 1, 15'h10, 15'h20, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk($sformatf("vb%0d cgnt", i), 32'(cpu_gnt_o), 1);
            chk($sformatf("vb%0d dgnt", i), 32'(disp_gnt_o), 0);
            chk($sformatf("vb%0d starved", i), 32'(cpu_starved_o), 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        drive(0, 1, 0, 15'h10, 15'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("mix D gnt", 32'(disp_gnt_o), 1);
        next_cycle();
        drive(0, 0, 1, 15'h0, 15'h20, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("mix C gnt", 32'(cpu_gnt_o), 1);
        chk("mix1 drv", 32'(disp_rvalid_o), 1);
        chk("mix1 drd", disp_rdata_o, 32'hDEADBEEF);
        chk("mix1 crv", 32'(cpu_rvalid_o), 0);
        next_cycle();
        drive(0, 1, 0, 15'h30, 15'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("mix D2 gnt", 32'(disp_gnt_o), 1);
        chk("mix2 crv", 32'(cpu_rvalid_o), 1);
        chk("mix2 crd", cpu_rdata_o, 32'h00005678);
        chk("mix2 drv", 32'(disp_rvalid_o), 0);
        chk("mix2 drd", disp_rdata_o, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("mix3 drv", 32'(disp_rvalid_o), 1);
        chk("mix3 drd", disp_rdata_o, 32'hAABBCCDD);
        chk("mix3 crv", 32'(cpu_rvalid_o), 0);
        next_cycle();
        @(negedge clk_i);
        chk("mix idle drv", 32'(disp_rvalid_o), 0);
        chk("mix idle crv", 32'(cpu_rvalid_o), 0);
        next_cycle();

        drive(0, 1, 0, 15'h10, 15'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("rst pre gnt", 32'(disp_gnt_o), 1);
        #1 rst_ni = 0;
        #1 chk("rst async gnt", 32'(disp_gnt_o), 0);
        next_cycle();
        chk("rst drop drv", 32'(disp_rvalid_o), 0);
        drive(0, 1, 1, 15'h10, 15'h20, 32'h3, 4'hF);
        @(negedge clk_i);
        chk_all_zero("rst held");
        next_cycle();
        rst_ni = 1;
        @(negedge clk_i);
        chk("rel gnt", 32'(disp_gnt_o), 1);
        chk("rel no drv", 32'(disp_rvalid_o), 0);
        chk("rel no crv", 32'(cpu_rvalid_o), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("rel drv", 32'(disp_rvalid_o), 1);
        chk("rel drd", disp_rdata_o, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
